router_input_fifo: RTL and testbench
====================================

Name: router_input_fifo

Overview:
Input buffer for one router port, sitting directly upstream of the per-output arbiters and the crossbar. It accepts flits from the neighbouring router over the RTS/CTS link handshake. The flits are stored in a small circular FIFO. The head flit is presented to the crossbar, and it is popped when any output arbiter grants this input.

Parameters:
DATA_WIDTH, 32, flit width in bits
DEPTH, 4, FIFO slots; power of two, ≥2
PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
DRTS  input  1  upstream request-to-send; RX valid while high
CTS  output  1  clear-to-send to upstream, registered, one-cycle pulse per accepted flit
RX  input  DATA_WIDTH  incoming flit
read_en_N  input  1  grant from N output arbiter
read_en_E  input  1  grant from E output arbiter
read_en_W  input  1  grant from W output arbiter
read_en_S  input  1  grant from S output arbiter
read_en_L  input  1  grant from L output arbiter
Data_out  output  DATA_WIDTH  head flit, combinational from mem[rd_ptr]
empty  output  1  FIFO empty
full  output  1  FIFO full
count  output  PTR_W+1  occupancy, 0..DEPTH

Behaviour:
- Reset values: CTS=0, rd_ptr=0, wr_ptr=0, count=0, empty=1, full=0. Storage is not reset, and Data_out is undefined while empty.
- Write acceptance: accept = DRTS & ~CTS & ~full, evaluated on current-cycle state.
- On accept: mem[wr_ptr] <= RX, wr_ptr increments mod DEPTH, and CTS <= 1 at the next edge. In every other case CTS <= 0. CTS is therefore never high for two consecutive cycles.
- Handshake timing: the upstream arbiter sees CTS at t+1 and drops RTS at t+2. In cycle t+1, DRTS is still high but CTS=1, so no duplicate write occurs. This gives a maximum rate of one flit per 3 cycles per link.
- Read: read_en = OR of the five read_en_* inputs. pop = read_en & ~empty. On pop, rd_ptr increments mod DEPTH.
- Read latency: Data_out reflects the new head in the cycle after the pop edge. A written flit is visible on Data_out one cycle after its accept edge, so write-to-read latency is 1 cycle.
- Occupancy update:
  - count += 1 on accept only
  - count -= 1 on pop only
  - count unchanged on accept and pop in the same cycle; both pointers advance
- Flags: empty = (count==0), full = (count==DEPTH). Both are derived from registered count.
- Full boundary: when full and a pop occurs in the same cycle, the write is still refused (accept uses pre-pop full). CTS stays 0 and the upstream keeps DRTS high, so the flit is accepted the next cycle.
- Empty boundary: read_en while empty is ignored; pointers and count are unchanged.
- Wrap-around: pointers wrap DEPTH-1 → 0 with no bubble.
- Reset mid-operation: all stored flits are discarded and CTS drops at the reset edge. A flit being accepted in the same cycle as rst=1 is not written.

Optional Feature:
Macro FIFO_ERR_CHK_EN.
- Defined: adds output err_flags[2:0], sticky, cleared only by rst.
  - bit0: read_en while empty
  - bit1: more than one read_en_* high in the same cycle (grants not one-hot)
  - bit2: DRTS falls while CTS=0 and a flit has been requested but not accepted (upstream protocol violation)
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package router_pkg holds:
  - DATA_WIDTH default
  - port index constants N=0, E=1, W=2, S=3, L=4
  - the err_flags bit index constants
- One sub-module, router_fifo_mem: a DEPTH×DATA_WIDTH register array with one synchronous write port and one asynchronous read port. Pointer, count and handshake logic stay in router_input_fifo.

Test Plan:
- Reset then idle: rst for 2 cycles → CTS=0, empty=1, full=0, count=0; read_en_N=1 changes nothing.
- Single flit: DRTS=1, RX=0xA5A5_0001 at t → CTS=1 at t+1 only, count=1 and empty=0 at t+1, Data_out=0xA5A5_0001; read_en_L=1 one cycle → empty=1 the next cycle.
- Fill to full: 4 handshakes with RX=1,2,3,4, no reads → full=1, count=4; a 5th DRTS gets no CTS until read_en_E pops; then CTS pulses and the flit is accepted; pop order is 1,2,3,4,5.
- Simultaneous accept and pop at count=2 → count stays 2, both pointers advance; wrap check over 10 flits shows in-order data.
- Reset mid-stream: count=3, assert rst in the same cycle as an accept → count=0, CTS=0, empty=1 next cycle, and the flit is not stored.
- With FIFO_ERR_CHK_EN: read_en_N and read_en_S high together with count=1 → err_flags[1]=1 sticky and one pop only (count=0); then read_en while empty → err_flags[0]=1.

Source files
------------

// File: rtl/router_pkg.sv
// Shared constants for the router input port.
// Holds default widths, output port indices and error flag bit positions.
package router_pkg;

    localparam int DATA_WIDTH_DEF = 32;

    localparam int NUM_PORTS = 5;
    localparam int PORT_N    = 0;
    localparam int PORT_E    = 1;
    localparam int PORT_W    = 2;
    localparam int PORT_S    = 3;
    localparam int PORT_L    = 4;

    localparam int ERR_W           = 3;
    localparam int ERR_RD_EMPTY    = 0;
    localparam int ERR_MULTI_GRANT = 1;
    localparam int ERR_PROTO       = 2;

endpackage

// File: rtl/router_fifo_mem.sv
// Flit storage for the router input FIFO.
// One synchronous write port, one asynchronous read port, no reset.
module router_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int PTR_W      = 2
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [PTR_W-1:0]      wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0]      rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Store the incoming flit into the addressed slot
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_input_fifo.sv
// Router input port buffer: RTS/CTS link receiver feeding a circular FIFO.
// Optional sticky error flags are built when FIFO_ERR_CHK_EN is defined.
module router_input_fifo
    import router_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int DEPTH      = 4,
    localparam int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  DRTS,
    output logic                  CTS,
    input  logic [DATA_WIDTH-1:0] RX,
    input  logic                  read_en_N,
    input  logic                  read_en_E,
    input  logic                  read_en_W,
    input  logic                  read_en_S,
    input  logic                  read_en_L,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  empty,
    output logic                  full,
    output logic [PTR_W:0]        count
`ifdef FIFO_ERR_CHK_EN
    ,
    output logic [ERR_W-1:0]      err_flags
`endif
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W:0]       count_next;
    logic [NUM_PORTS-1:0] grant;
    logic                 read_en;
    logic                 pop;
    logic                 accept;

    // Gather the arbiter grants into one vector indexed by port
    always_comb begin
        grant         = '0;
        grant[PORT_N] = read_en_N;
        grant[PORT_E] = read_en_E;
        grant[PORT_W] = read_en_W;
        grant[PORT_S] = read_en_S;
        grant[PORT_L] = read_en_L;
    end

    assign read_en = |grant;
    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop     = read_en & ~empty;
    // CTS high means the current RTS was already served last cycle
    assign accept  = DRTS & ~CTS & ~full;

    router_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (accept & ~rst),
        .wr_addr (wr_ptr),
        .wr_data (RX),
        .rd_addr (rd_ptr),
        .rd_data (Data_out)
    );

    // Pulse CTS for exactly one cycle after each accepted flit
    always_ff @(posedge clk) begin
        if (rst) begin
            CTS <= 1'b0;
        end else begin
            CTS <= accept;
        end
    end

    // Advance write and read pointers; power-of-two depth wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Work out next occupancy from this cycle's accept and pop
    always_comb begin
        count_next = count;
        unique case ({accept, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Register occupancy; flags are decoded from this register
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

`ifdef FIFO_ERR_CHK_EN
    logic             drts_q;
    logic             served;
    logic [ERR_W-1:0] err_set;

    // Detect grant misuse and upstream withdrawing an unserved request
    always_comb begin
        err_set = '0;
        err_set[ERR_RD_EMPTY] = read_en & empty;
        err_set[ERR_MULTI_GRANT] =
            |(grant & (grant - {{(NUM_PORTS-1){1'b0}}, 1'b1}));
        err_set[ERR_PROTO] = drts_q & ~DRTS & ~CTS & ~served;
    end

    // Track the current request and accumulate sticky error bits
    always_ff @(posedge clk) begin
        if (rst) begin
            drts_q    <= 1'b0;
            served    <= 1'b0;
            err_flags <= '0;
        end else begin
            drts_q    <= DRTS;
            served    <= DRTS & (served | accept);
            err_flags <= err_flags | err_set;
        end
    end
`endif

endmodule

// File: tb/tb_router_input_fifo.sv
// Directed bench for router_input_fifo with a flit scoreboard.
// Define FIFO_ERR_CHK_EN to also exercise the error flag outputs.
module tb_router_input_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        DRTS;
    logic        CTS;
    logic [31:0] RX;
    logic        read_en_N;
    logic        read_en_E;
    logic        read_en_W;
    logic        read_en_S;
    logic        read_en_L;
    logic [31:0] Data_out;
    logic        empty;
    logic        full;
    logic [2:0]  count;
`ifdef FIFO_ERR_CHK_EN
    logic [2:0]  err_flags;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    router_input_fifo #(
        .DATA_WIDTH (32),
        .DEPTH      (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .DRTS      (DRTS),
        .CTS       (CTS),
        .RX        (RX),
        .read_en_N (read_en_N),
        .read_en_E (read_en_E),
        .read_en_W (read_en_W),
        .read_en_S (read_en_S),
        .read_en_L (read_en_L),
        .Data_out  (Data_out),
        .empty     (empty),
        .full      (full),
        .count     (count)
`ifdef FIFO_ERR_CHK_EN
        ,
        .err_flags (err_flags)
`endif
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Upstream sender: hold RTS until CTS, then one more cycle, then drop
    task automatic send(input logic [31:0] d);
        int n;
        n    = 0;
        RX   = d;
        DRTS = 1'b1;
        do begin
            tick();
            n++;
        end while (CTS !== 1'b1 && n < 20);
        check("cts_seen", {31'b0, CTS}, 32'd1);
        if (CTS === 1'b1) sb.push_back(d);
        tick();
        check("cts_pulse", {31'b0, CTS}, 32'd0);
        DRTS = 1'b0;
    endtask

    // Compare head against scoreboard, then grant for one cycle
    task automatic pop_check(input string tag, input int port);
        logic [31:0] e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=%h expected=scoreboard_entry", tag,
                   Data_out);
        end else begin
            e = sb.pop_front();
            check(tag, Data_out, e);
        end
        case (port)
            0: read_en_N = 1'b1;
            1: read_en_E = 1'b1;
            2: read_en_W = 1'b1;
            3: read_en_S = 1'b1;
            default: read_en_L = 1'b1;
        endcase
        tick();
        read_en_N = 1'b0;
        read_en_E = 1'b0;
        read_en_W = 1'b0;
        read_en_S = 1'b0;
        read_en_L = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        DRTS = 1'b0;
        RX = '0;
        read_en_N = 1'b0;
        read_en_E = 1'b0;
        read_en_W = 1'b0;
        read_en_S = 1'b0;
        read_en_L = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_cts", {31'b0, CTS}, 32'd0);
        check("rst_empty", {31'b0, empty}, 32'd1);
        check("rst_full", {31'b0, full}, 32'd0);
        check("rst_count", {29'b0, count}, 32'd0);

        read_en_N = 1'b1;
        tick();
        read_en_N = 1'b0;
        check("idle_rd_count", {29'b0, count}, 32'd0);
        check("idle_rd_empty", {31'b0, empty}, 32'd1);

        RX = 32'hA5A5_0001;
        DRTS = 1'b1;
        tick();
        check("single_cts", {31'b0, CTS}, 32'd1);
        check("single_count", {29'b0, count}, 32'd1);
        check("single_empty", {31'b0, empty}, 32'd0);
        sb.push_back(32'hA5A5_0001);
        tick();
        check("single_cts_low", {31'b0, CTS}, 32'd0);
        check("single_no_dup", {29'b0, count}, 32'd1);
        DRTS = 1'b0;
        pop_check("single_data", 4);
        check("single_empty_after", {31'b0, empty}, 32'd1);

        for (int i = 1; i <= 4; i++) send(i);
        check("fill_full", {31'b0, full}, 32'd1);
        check("fill_count", {29'b0, count}, 32'd4);
        RX = 32'd5;
        DRTS = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_no_cts", {31'b0, CTS}, 32'd0);
        end
        pop_check("full_pop1", 1);
        check("full_pop_refuse", {31'b0, CTS}, 32'd0);
        check("full_pop_count", {29'b0, count}, 32'd3);
        tick();
        check("full_late_cts", {31'b0, CTS}, 32'd1);
        check("full_late_count", {29'b0, count}, 32'd4);
        sb.push_back(32'd5);
        tick();
        check("full_late_cts_low", {31'b0, CTS}, 32'd0);
        DRTS = 1'b0;
        for (int i = 0; i < 4; i++) pop_check("full_order", 1);
        check("drain_empty", {31'b0, empty}, 32'd1);

        send(32'd6);
        send(32'd7);
        check("sim_pre_count", {29'b0, count}, 32'd2);
        RX = 32'd8;
        DRTS = 1'b1;
        pop_check("sim_head", 2);
        check("sim_count", {29'b0, count}, 32'd2);
        check("sim_cts", {31'b0, CTS}, 32'd1);
        sb.push_back(32'd8);
        tick();
        DRTS = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send(32'd100 + 32'(i));
            pop_check("wrap_data", 3);
        end
        pop_check("wrap_tail", 3);
        pop_check("wrap_tail", 3);
        check("wrap_empty", {31'b0, empty}, 32'd1);

        send(32'hB001);
        send(32'hB002);
        send(32'hB003);
        check("mid_count", {29'b0, count}, 32'd3);
        RX = 32'hDEAD_BEEF;
        DRTS = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        DRTS = 1'b0;
        sb.delete();
        check("mid_rst_count", {29'b0, count}, 32'd0);
        check("mid_rst_cts", {31'b0, CTS}, 32'd0);
        check("mid_rst_empty", {31'b0, empty}, 32'd1);
        tick();
        check("mid_rst_hold", {29'b0, count}, 32'd0);
        send(32'h1234_5678);
        pop_check("post_rst_data", 0);

`ifdef FIFO_ERR_CHK_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("err_rst", {29'b0, err_flags}, 32'd0);
        send(32'hC0DE);
        check("err_clean_send", {29'b0, err_flags}, 32'd0);
        read_en_N = 1'b1;
        read_en_S = 1'b1;
        tick();
        read_en_N = 1'b0;
        read_en_S = 1'b0;
        check("err_multi", {29'b0, err_flags}, 32'd2);
        check("err_multi_count", {29'b0, count}, 32'd0);
        tick();
        check("err_sticky", {29'b0, err_flags}, 32'd2);
        read_en_N = 1'b1;
        tick();
        read_en_N = 1'b0;
        check("err_rd_empty", {29'b0, err_flags}, 32'd3);
        for (int i = 0; i < 4; i++) send(32'hE0 + 32'(i));
        RX = 32'hE9;
        DRTS = 1'b1;
        tick();
        tick();
        check("err_proto_wait", {29'b0, err_flags}, 32'd3);
        DRTS = 1'b0;
        tick();
        check("err_proto", {29'b0, err_flags}, 32'd7);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
